fifo_multicanal: RTL and testbench

Bank of NUM_CANALES independent FIFOs, parametrised in data width, depth and channel count. Has one shared write port steered by a channel select and one read enable per channel. Successor to the single-channel FIFO, adding:
- programmable almost-full and almost-empty thresholds
- overflow/underflow protection with sticky per-channel error flags
- error clear input
Sits between the packet-distribution front end and per-lane consumers.

---
 rtl/fifo_multicanal_pkg.sv | 24 ++
 rtl/fifo_canal.sv | 98 +++++++++
 rtl/fifo_multicanal.sv | 59 +++++
 tb/tb_fifo_multicanal.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/fifo_multicanal_pkg.sv
// Shared sizing, counter type and slice helpers for the multi-channel FIFO bank.
// No logic; constants and functions only.
// Not applicable (no handshakes here).
package fifo_multicanal_pkg;

    // Default channel geometry: 3-bit addresses give an 8-deep channel.
    localparam int TAMANO_DIRECCION_DEF = 3;
    localparam int PROF                 = 2 ** TAMANO_DIRECCION_DEF;
    localparam int CONT_W               = TAMANO_DIRECCION_DEF + 1;

    // Occupancy counter for the default geometry; one extra bit so PROF fits.
    typedef logic [CONT_W-1:0] contador_t;

    // Depth of a channel for a given address width.
    function automatic int prof_de(input int ancho_dir);
        return 2 ** ancho_dir;
    endfunction

    // Bit offset of channel c inside the packed data_out bus.
    function automatic int offset_datos(input int canal, input int ancho_datos);
        return canal * ancho_datos;
    endfunction

endpackage

// File: rtl/fifo_canal.sv
// One FIFO channel: memory, pointers, occupancy counter, status flags, sticky error.
// Read data one cycle after an accepted read (or fall-through with FIFO_MULTICANAL_FWFT_EN).
// Writes to a full channel are dropped unless a read frees a slot in the same cycle.
import fifo_multicanal_pkg::*;

module fifo_canal #(
    parameter int TAMANO_DATOS     = 10,
    parameter int TAMANO_DIRECCION = 3
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        wr,
    input  logic                        rd,
    input  logic [TAMANO_DATOS-1:0]     data_in,
    input  logic [TAMANO_DIRECCION:0]   umbral_alto,
    input  logic [TAMANO_DIRECCION:0]   umbral_bajo,
    input  logic                        err_clr,
    output logic [TAMANO_DATOS-1:0]     data_out,
    output logic                        full,
    output logic                        empty,
    output logic                        almost_full,
    output logic                        almost_empty,
    output logic                        error
);

    localparam int PROF_C = prof_de(TAMANO_DIRECCION);
    localparam int CONT_C = TAMANO_DIRECCION + 1;

    logic [TAMANO_DATOS-1:0]     mem [PROF_C];
    logic [TAMANO_DIRECCION-1:0] wr_ptr;
    logic [TAMANO_DIRECCION-1:0] rd_ptr;
    logic [CONT_C-1:0]           contador;

    logic rd_ok;
    logic wr_ok;
    logic overflow;
    logic underflow;

    // Status is purely combinational from the registered count and live thresholds.
    assign full         = (contador == CONT_C'(PROF_C));
    assign empty        = (contador == '0);
    assign almost_full  = (contador >= umbral_alto);
    assign almost_empty = (contador <= umbral_bajo);

    // A read on full frees the slot the simultaneous write lands in; a read on empty never helps.
    assign rd_ok     = rd && !empty;
    assign wr_ok     = wr && (!full || rd_ok);
    assign overflow  = wr && !wr_ok;
    assign underflow = rd && empty;

    // Pointers and occupancy; rejected operations leave them untouched.
    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            contador <= '0;
        end else begin
            if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
            if (rd_ok) rd_ptr <= rd_ptr + 1'b1;
            case ({wr_ok, rd_ok})
                2'b10:   contador <= contador + 1'b1;
                2'b01:   contador <= contador - 1'b1;
                default: contador <= contador;
            endcase
        end
    end

    // Storage is never cleared; stale words are unreachable once the pointers reset.
    always_ff @(posedge clk) begin
        if (reset && wr_ok) mem[wr_ptr] <= data_in;
    end

    // Sticky error: a fresh fault outranks a clear issued in the same cycle.
    always_ff @(posedge clk) begin
        if (!reset)                     error <= 1'b0;
        else if (overflow || underflow) error <= 1'b1;
        else if (err_clr)               error <= 1'b0;
    end

`ifdef FIFO_MULTICANAL_FWFT_EN
    // Head of the queue is always visible; zero while the channel is empty.
    always_comb begin
        data_out = '0;
        if (!empty) data_out = mem[rd_ptr];
    end
`else
    logic [TAMANO_DATOS-1:0] dato_q;

    // Registered read: word captured on an accepted read and held until the next one.
    always_ff @(posedge clk) begin
        if (!reset)     dato_q <= '0;
        else if (rd_ok) dato_q <= mem[rd_ptr];
    end

    assign data_out = dato_q;
`endif

endmodule

// File: rtl/fifo_multicanal.sv
// Bank of NUM_CANALES independent FIFOs with a shared steered write port and per-channel reads.
// Read latency 1 cycle; with FIFO_MULTICANAL_FWFT_EN defined the head word falls through combinationally.
// No stall outputs: overflowing writes and underflowing reads are dropped and flagged in error[c].
import fifo_multicanal_pkg::*;

module fifo_multicanal #(
    parameter int TAMANO_DATOS     = 10,
    parameter int TAMANO_DIRECCION = 3,
    parameter int NUM_CANALES      = 4,
    parameter int SEL_W            = $clog2(NUM_CANALES)
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic                                wr_en,
    input  logic [SEL_W-1:0]                    wr_sel,
    input  logic [TAMANO_DATOS-1:0]             data_in,
    input  logic [NUM_CANALES-1:0]              rd_en,
    input  logic [TAMANO_DIRECCION:0]           umbral_alto,
    input  logic [TAMANO_DIRECCION:0]           umbral_bajo,
    input  logic [NUM_CANALES-1:0]              err_clr,
    output logic [NUM_CANALES*TAMANO_DATOS-1:0] data_out,
    output logic [NUM_CANALES-1:0]              full,
    output logic [NUM_CANALES-1:0]              empty,
    output logic [NUM_CANALES-1:0]              almost_full,
    output logic [NUM_CANALES-1:0]              almost_empty,
    output logic [NUM_CANALES-1:0]              error
);

    logic [NUM_CANALES-1:0] wr_vec;

    // One-hot steering of the shared write port.
    always_comb begin
        wr_vec = '0;
        if (wr_en) wr_vec = NUM_CANALES'(1) << wr_sel;
    end

    for (genvar c = 0; c < NUM_CANALES; c++) begin : g_canal
        fifo_canal #(
            .TAMANO_DATOS     (TAMANO_DATOS),
            .TAMANO_DIRECCION (TAMANO_DIRECCION)
        ) u_canal (
            .clk          (clk),
            .reset        (reset),
            .wr           (wr_vec[c]),
            .rd           (rd_en[c]),
            .data_in      (data_in),
            .umbral_alto  (umbral_alto),
            .umbral_bajo  (umbral_bajo),
            .err_clr      (err_clr[c]),
            .data_out     (data_out[offset_datos(c, TAMANO_DATOS) +: TAMANO_DATOS]),
            .full         (full[c]),
            .empty        (empty[c]),
            .almost_full  (almost_full[c]),
            .almost_empty (almost_empty[c]),
            .error        (error[c])
        );
    end

endmodule

// File: tb/tb_fifo_multicanal.sv
// Scoreboard bench for fifo_multicanal: queue-based reference model, directed plan then random traffic.
// Expected outputs pushed per cycle by the stimulus, popped and compared by an independent monitor.
// Covers FIFO_MULTICANAL_FWFT_EN when that macro is defined for the build.
module tb_fifo_multicanal;

    localparam int DW   = 10;
    localparam int AW   = 3;
    localparam int NC   = 4;
    localparam int PROF = 8;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              wr_en = 1'b0;
    logic [1:0]        wr_sel = '0;
    logic [DW-1:0]     data_in = '0;
    logic [NC-1:0]     rd_en = '0;
    logic [AW:0]       umbral_alto = 4'd7;
    logic [AW:0]       umbral_bajo = 4'd1;
    logic [NC-1:0]     err_clr = '0;
    logic [NC*DW-1:0]  data_out;
    logic [NC-1:0]     full, empty, almost_full, almost_empty, error;

    fifo_multicanal #(
        .TAMANO_DATOS(DW), .TAMANO_DIRECCION(AW), .NUM_CANALES(NC)
    ) dut (
        .clk(clk), .reset(reset), .wr_en(wr_en), .wr_sel(wr_sel), .data_in(data_in),
        .rd_en(rd_en), .umbral_alto(umbral_alto), .umbral_bajo(umbral_bajo),
        .err_clr(err_clr), .data_out(data_out), .full(full), .empty(empty),
        .almost_full(almost_full), .almost_empty(almost_empty), .error(error)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [NC-1:0]    full;
        logic [NC-1:0]    empty;
        logic [NC-1:0]    af;
        logic [NC-1:0]    ae;
        logic [NC-1:0]    err;
        logic [NC*DW-1:0] dout;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model: one word queue per channel, sticky error bits, held read word.
    int unsigned mq[NC][$];
    logic [NC-1:0] m_err = '0;
    int unsigned   m_held[NC];

    // Thresholds the next cycle will drive.
    logic [AW:0] ua = 4'd7;
    logic [AW:0] ub = 4'd1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, expv, $time);
        end
    endtask

    // One clock of stimulus; the model is advanced with the same inputs.
    task automatic cyc(input logic rst_n, input logic we, input int sel, input int d,
                       input logic [NC-1:0] re, input logic [NC-1:0] clr);
        exp_t e;
        @(negedge clk);
        reset = rst_n; wr_en = we; wr_sel = 2'(sel); data_in = DW'(d);
        rd_en = re; err_clr = clr; umbral_alto = ua; umbral_bajo = ub;
        for (int c = 0; c < NC; c++) begin
            if (!rst_n) begin
                mq[c].delete();
                m_err[c]  = 1'b0;
                m_held[c] = 0;
            end else begin
                bit rd_ok, wr_ok, bad;
                int unsigned w;
                rd_ok = re[c] && (mq[c].size() > 0);
                wr_ok = we && (sel == c) && ((mq[c].size() < PROF) || rd_ok);
                bad   = (we && (sel == c) && !wr_ok) || (re[c] && mq[c].size() == 0);
                if (rd_ok) begin
                    w = mq[c].pop_front();
                    m_held[c] = w;
                end
                if (wr_ok) mq[c].push_back(d & 32'h3FF);
                if (bad) m_err[c] = 1'b1;
                else if (clr[c]) m_err[c] = 1'b0;
            end
        end
        for (int c = 0; c < NC; c++) begin
            int n;
            n = mq[c].size();
            e.full[c]  = (n == PROF);
            e.empty[c] = (n == 0);
            e.af[c]    = (n >= int'(ua));
            e.ae[c]    = (n <= int'(ub));
            e.err[c]   = m_err[c];
`ifdef FIFO_MULTICANAL_FWFT_EN
            e.dout[c*DW +: DW] = (n == 0) ? '0 : DW'(mq[c][0]);
`else
            e.dout[c*DW +: DW] = DW'(m_held[c]);
`endif
        end
        exp_q.push_back(e);
    endtask

    // Monitor: compare DUT outputs shortly after each edge against the queued expectation.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                exp_t e;
                e = exp_q.pop_front();
                chk("full", 64'(full), 64'(e.full));
                chk("empty", 64'(empty), 64'(e.empty));
                chk("almost_full", 64'(almost_full), 64'(e.af));
                chk("almost_empty", 64'(almost_empty), 64'(e.ae));
                chk("error", 64'(error), 64'(e.err));
                for (int c = 0; c < NC; c++)
                    chk($sformatf("data_out[%0d]", c), 64'(data_out[c*DW +: DW]), 64'(e.dout[c*DW +: DW]));
            end
        end
    end

    initial begin
        // Reset.
        cyc(0, 0, 0, 0, '0, '0);
        cyc(0, 1, 1, 5, 4'hF, '0);
        // Fill channel 2 with 1..8, ninth write overflows.
        ua = 4'd7; ub = 4'd1;
        for (int i = 1; i <= 9; i++) cyc(1, 1, 2, i, '0, '0);
        cyc(1, 0, 0, 0, '0, '0);
        // Drain channel 2, ninth read underflows and data holds.
        for (int i = 0; i < 9; i++) cyc(1, 0, 0, 0, 4'b0100, '0);
        cyc(1, 0, 0, 0, '0, 4'b0100);
        // Channel 1 full, simultaneous write+read, then drain across the wrap.
        for (int i = 0; i < PROF; i++) cyc(1, 1, 1, 16'h40 + i, '0, '0);
        cyc(1, 1, 1, 16'h3FF, 4'b0010, '0);
        for (int i = 0; i < PROF; i++) cyc(1, 0, 0, 0, 4'b0010, '0);
        // Empty channel 0: write accepted, read underflows; then clear.
        cyc(1, 1, 0, 16'h2A, 4'b0001, '0);
        cyc(1, 0, 0, 0, '0, 4'b0001);
        // Error in the same cycle as clear keeps error set.
        cyc(1, 0, 0, 0, 4'b1000, 4'b1000);
        cyc(1, 0, 0, 0, '0, 4'b1000);
        // Fall-through pattern on channel 3 (registered mode checks hold/latency).
        cyc(1, 1, 3, 16'h155, '0, '0);
        cyc(1, 0, 0, 0, '0, '0);
        cyc(1, 0, 0, 0, 4'b1000, '0);
        cyc(1, 0, 0, 0, '0, '0);
        // Threshold boundaries including values above depth.
        ua = 4'd15; ub = 4'd0;
        cyc(1, 1, 1, 7, '0, '0);
        ua = 4'd9; ub = 4'd8;
        cyc(1, 0, 0, 0, '0, '0);
        // Reset with enables active discards everything.
        cyc(0, 1, 1, 9, 4'hF, '0);
        cyc(1, 0, 0, 0, 4'hF, '0);
        // Random traffic.
        for (int i = 0; i < 1500; i++) begin
            logic [NC-1:0] re, clr;
            if (i % 60 == 0) begin
                ua = 4'($urandom_range(0, 15));
                ub = 4'($urandom_range(0, 15));
            end
            for (int c = 0; c < NC; c++) begin
                re[c]  = ($urandom_range(0, 99) < 35);
                clr[c] = ($urandom_range(0, 99) < 5);
            end
            cyc(($urandom_range(0, 299) != 0), ($urandom_range(0, 99) < 60),
                int'($urandom_range(0, NC-1)), int'($urandom_range(0, 1023)), re, clr);
        end
        cyc(1, 0, 0, 0, '0, '0);
        repeat (3) @(posedge clk);
        #2;
        chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
